hilo_div_seq: RTL

Iterative 32-bit radix-2 restoring divider producing MIPS DIV/DIVU results for the Hi/Lo register pair. Sits directly beside the ALU stage: the ALU holds `validIn` high and stalls the pipeline until `validOut` pulses, then latches `Hi` (remainder) and `Lo` (quotient). Handles both signed and unsigned operation on one shared datapath, with sign correction applied once at the end.

---
 rtl/hilo_div_seq_if.sv | 24 ++
 rtl/hilo_div_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/hilo_div_seq_if.sv
// Request/response bundle between the ALU stage and the Hi/Lo divider.
// The ALU side uses the master modport and the divider uses the slave modport.
interface hilo_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             validIn;
    logic             sign;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             validOut;
    logic             busy;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output validIn, sign, SrcA, SrcB,
        input  validOut, busy, Hi, Lo
    );

    modport slave (
        input  validIn, sign, SrcA, SrcB,
        output validOut, busy, Hi, Lo
    );
endinterface

// File: rtl/hilo_div_seq.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: Hi = remainder, Lo = quotient.
// Defining HILO_DIV_ZERO_FAST_EN makes a zero divisor bypass the 32 shift/subtract steps.
//
// state | meaning
// IDLE  | waiting for validIn, operands captured on acceptance
// BUSY  | one restoring step per cycle, WIDTH steps
// FIX   | sign correction, Hi/Lo written
// DONE  | validOut pulse; a new request is accepted here as well
module hilo_div_seq #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    hilo_div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

`ifdef HILO_DIV_ZERO_FAST_EN
    localparam logic FAST_ZERO = 1'b1;
`else
    localparam logic FAST_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   div_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] raw_a_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             qneg_q, rneg_q, zero_q;

    logic             capture, zero_in, a_neg, b_neg, last_step, fit;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH+1:0] shifted, diff;

    assign capture   = bus.validIn && (state_q == IDLE || state_q == DONE);
    assign zero_in   = (bus.SrcB == '0);
    assign a_neg     = bus.sign & bus.SrcA[WIDTH-1];
    assign b_neg     = bus.sign & bus.SrcB[WIDTH-1];
    assign a_mag     = a_neg ? -bus.SrcA : bus.SrcA;
    // Divisor magnitude is one bit wider so |most-negative| stays exact.
    assign b_mag     = b_neg ? (~{bus.SrcB[WIDTH-1], bus.SrcB} + ONE) : {1'b0, bus.SrcB};
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, div_q};
    assign fit       = ~diff[WIDTH+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (capture) state_d = (FAST_ZERO && zero_in) ? FIX : BUSY;
            BUSY: if (last_step) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                state_d = IDLE;
                if (capture) state_d = (FAST_ZERO && zero_in) ? FIX : BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            raw_a_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (capture) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= b_mag;
            quo_q   <= a_mag;
            raw_a_q <= bus.SrcA;
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            zero_q  <= zero_in;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CW'(1);
            rem_q <= fit ? diff[WIDTH:0] : shifted[WIDTH:0];
            quo_q <= {quo_q[WIDTH-2:0], fit};
        end else if (state_q == FIX) begin
            // Zero divisor bypasses sign correction so Hi is the untouched dividend.
            if (zero_q) begin
                lo_q <= '1;
                hi_q <= raw_a_q;
            end else begin
                lo_q <= qneg_q ? -quo_q : quo_q;
                hi_q <= rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            end
        end
    end

    assign bus.validOut = (state_q == DONE);
    assign bus.busy     = (state_q == BUSY) || (state_q == FIX);
    assign bus.Hi       = hi_q;
    assign bus.Lo       = lo_q;
endmodule
